// File: rtl/heart_pkg.sv
// Shared constants and types for the heart life-counter overlay.
// Sprite geometry, transparent colour and the blink FSM state encoding.
package heart_pkg;

    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 20;

    localparam logic [15:0] TRANSPARENT = 16'h0000;

    typedef enum logic {
        IDLE,
        BLINK
    } blink_state_e;

endpackage

// File: rtl/heart_blink_fsm.sv
// Blink sequencer for the most recently lost heart slot.
// Only instantiated when HEART_BLINK_EN is defined.
module heart_blink_fsm
    import heart_pkg::*;
#(
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       dec_accept,
    input  logic       inc_accept,
    input  logic [2:0] new_lives,
    output logic       blink_active,
    output logic [2:0] blink_idx,
    output logic       blink_on
);

    localparam int CNT_W = 16;

    blink_state_e     state, state_nx;
    logic [CNT_W-1:0] frame_cnt, frame_nx;
    logic [CNT_W-1:0] toggle_cnt, toggle_nx;
    logic [2:0]       idx_nx;
    logic             on_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            blink_idx  <= '0;
            blink_on   <= 1'b0;
        end else begin
            state      <= state_nx;
            frame_cnt  <= frame_nx;
            toggle_cnt <= toggle_nx;
            blink_idx  <= idx_nx;
            blink_on   <= on_nx;
        end
    end

    // A new loss always wins: it restarts the sequence on the freshly lost slot.
    always_comb begin
        state_nx  = state;
        frame_nx  = frame_cnt;
        toggle_nx = toggle_cnt;
        idx_nx    = blink_idx;
        on_nx     = blink_on;
        if (dec_accept) begin
            state_nx  = BLINK;
            idx_nx    = new_lives;
            on_nx     = 1'b1;
            frame_nx  = '0;
            toggle_nx = '0;
        end else if (state == BLINK) begin
            if (inc_accept) begin
                state_nx  = IDLE;
                frame_nx  = '0;
                toggle_nx = '0;
            end else if (frame_start) begin
                if (frame_cnt == CNT_W'(BLINK_PERIOD - 1)) begin
                    frame_nx  = '0;
                    on_nx     = ~blink_on;
                    toggle_nx = toggle_cnt + CNT_W'(1);
                    if (toggle_cnt == CNT_W'(BLINK_TOGGLES - 1)) begin
                        state_nx  = IDLE;
                        toggle_nx = '0;
                    end
                end else begin
                    frame_nx = frame_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign blink_active = (state == BLINK);

endmodule

// File: rtl/heart_display_ctrl.sv
// Heart (life counter) overlay: slot decode, ROM addressing, 2-stage pixel pipeline.
// Define HEART_BLINK_EN to make a lost heart blink before vanishing.
module heart_display_ctrl
    import heart_pkg::*;
#(
    parameter int HEART_X0      = 16,
    parameter int HEART_Y0      = 8,
    parameter int HEART_PITCH   = 68,
    parameter int MAX_LIVES     = 3,
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        frame_start,
    input  logic        life_lost,
    input  logic        life_gain,
    output logic [5:0]  rom_x,
    output logic [5:0]  rom_y,
    input  logic [15:0] rom_rgb,
    output logic [15:0] pixel_rgb,
    output logic        pixel_hit,
    output logic [2:0]  lives,
    output logic        game_over
);

    logic       region_hit;
    logic [2:0] region_slot;
    logic       slot_visible;
    logic       dec_accept, inc_accept;
    logic       blink_active, blink_on;
    logic [2:0] blink_idx;
    logic       hit_p1;

    assign dec_accept = life_lost && !life_gain && (lives != 3'd0);
    assign inc_accept = life_gain && !life_lost && (lives < 3'(MAX_LIVES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives     <= 3'(MAX_LIVES);
            game_over <= 1'b0;
        end else begin
            if (dec_accept)
                lives <= lives - 3'd1;
            else if (inc_accept)
                lives <= lives + 3'd1;
            game_over <= (lives == 3'd0);
        end
    end

`ifdef HEART_BLINK_EN
    heart_blink_fsm #(
        .BLINK_PERIOD (BLINK_PERIOD),
        .BLINK_TOGGLES(BLINK_TOGGLES)
    ) u_blink (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .dec_accept  (dec_accept),
        .inc_accept  (inc_accept),
        .new_lives   (lives - 3'd1),
        .blink_active(blink_active),
        .blink_idx   (blink_idx),
        .blink_on    (blink_on)
    );
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign blink_active       = 1'b0;
    assign blink_idx          = 3'd0;
    assign blink_on           = 1'b0;
`endif

    // Slots are at least one sprite width apart, so at most one can match.
    always_comb begin
        region_hit  = 1'b0;
        region_slot = 3'd0;
        rom_x       = 6'd0;
        rom_y       = 6'd0;
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (int'(hcount) >= HEART_X0 + k * HEART_PITCH &&
                int'(hcount) <  HEART_X0 + k * HEART_PITCH + SPRITE_W &&
                int'(vcount) >= HEART_Y0 &&
                int'(vcount) <  HEART_Y0 + SPRITE_H) begin
                region_hit  = 1'b1;
                region_slot = 3'(k);
                rom_x       = 6'(int'(hcount) - HEART_X0 - k * HEART_PITCH);
                rom_y       = 6'(int'(vcount) - HEART_Y0);
            end
        end
    end

    assign slot_visible = (region_slot < lives) ||
                          (blink_active && blink_on && (region_slot == blink_idx));

    // Stage 1: hit flag, aligned with the ROM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hit_p1 <= 1'b0;
        else
            hit_p1 <= region_hit && slot_visible;
    end

    // Stage 2: masked overlay colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_rgb <= TRANSPARENT;
            pixel_hit <= 1'b0;
        end else if (hit_p1 && (rom_rgb != TRANSPARENT)) begin
            pixel_rgb <= rom_rgb;
            pixel_hit <= 1'b1;
        end else begin
            pixel_rgb <= TRANSPARENT;
            pixel_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_heart_display_ctrl.sv
// Scoreboard bench for heart_display_ctrl with an external ROM model.
// Works with or without HEART_BLINK_EN defined.
module tb_heart_display_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hcount, vcount;
    logic        frame_start, life_lost, life_gain;
    logic [5:0]  rom_x, rom_y;
    logic [15:0] rom_rgb, pixel_rgb;
    logic        pixel_hit;
    logic [2:0]  lives;
    logic        game_over;

    always #5 clk = ~clk;

    heart_display_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_start(frame_start),
        .life_lost  (life_lost),
        .life_gain  (life_gain),
        .rom_x      (rom_x),
        .rom_y      (rom_y),
        .rom_rgb    (rom_rgb),
        .pixel_rgb  (pixel_rgb),
        .pixel_hit  (pixel_hit),
        .lives      (lives),
        .game_over  (game_over)
    );

    function automatic bit heart_bit(int x, int y);
        return ((x * 3 + y * 7 + (x ^ y)) % 5) < 3;
    endfunction

    always @(posedge clk)
        rom_rgb <= heart_bit(int'(rom_x), int'(rom_y)) ? 16'hf800 : 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] rgb;
    } exp_t;
    exp_t q[$];

    // Reference state: lives and the blink sequence as frames elapsed since the loss.
    int m_lives;
    bit m_go;
    bit m_bl;
    int m_idx;
    int m_frames;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    function automatic void region(int h, int v, output bit hit, output int slot,
                                   output int ox, output int oy);
        hit = 0; slot = 0; ox = 0; oy = 0;
        for (int k = 0; k < 3; k++) begin
            if (h >= 16 + 68 * k && h <= 16 + 68 * k + 63 && v >= 8 && v <= 27) begin
                hit = 1; slot = k; ox = h - 16 - 68 * k; oy = v - 8;
            end
        end
    endfunction

    function automatic bit visible(int slot);
        return (slot < m_lives) || (m_bl && slot == m_idx && ((m_frames / 8) % 2 == 0));
    endfunction

    function automatic void model_update(bit fs, bit lost, bit gain);
        m_go = (m_lives == 0);
        if (lost && !gain && m_lives > 0) begin
            m_lives--;
`ifdef HEART_BLINK_EN
            m_bl = 1; m_idx = m_lives; m_frames = 0;
`endif
        end else if (gain && !lost && m_lives < 3) begin
            m_lives++;
            m_bl = 0;
        end else if (m_bl && fs) begin
            m_frames++;
            if (m_frames == 8 * 6) m_bl = 0;
        end
    endfunction

    task automatic cycle(int h, int v, bit fs, bit lost, bit gain);
        bit hit;
        int slot, ox, oy;
        logic [15:0] rgb;
        hcount = 10'(h); vcount = 10'(v);
        frame_start = fs; life_lost = lost; life_gain = gain;
        region(h, v, hit, slot, ox, oy);
        rgb = (hit && visible(slot) && heart_bit(ox, oy)) ? 16'hf800 : 16'h0000;
        q.push_back('{cyc, rgb});
        @(negedge clk);
        check("rom_x", int'(rom_x), ox);
        check("rom_y", int'(rom_y), oy);
        check("lives", int'(lives), m_lives);
        check("game_over", int'(game_over), int'(m_go));
        @(posedge clk);
        model_update(fs, lost, gain);
        #1;
    endtask

    task automatic do_reset(int n);
        hcount = '0; vcount = '0;
        frame_start = 0; life_lost = 0; life_gain = 0;
        rst_n = 0;
        q.delete();
        #1;
        check("rst_pixel_rgb", int'(pixel_rgb), 0);
        check("rst_pixel_hit", int'(pixel_hit), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_game_over", int'(game_over), 0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1;
        m_lives = 3; m_go = 0; m_bl = 0; m_idx = 0; m_frames = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
                exp_t e;
                e = q.pop_front();
                check("pixel_rgb", int'(pixel_rgb), int'(e.rgb));
                check("pixel_hit", int'(pixel_hit), int'(e.rgb != 16'h0000));
            end
        end
    end

    task automatic slot2_frames(int nframes);
        for (int f = 0; f < nframes; f++) begin
            cycle(0, 0, 1, 0, 0);
            for (int i = 0; i < 6; i++)
                cycle(152 + int'($urandom_range(0, 63)), 8 + int'($urandom_range(0, 19)), 0, 0, 0);
        end
    endtask

    initial begin
        rst_n = 1;
        hcount = '0; vcount = '0;
        frame_start = 0; life_lost = 0; life_gain = 0;
        #2;
        do_reset(2);

        // Full sweep of slot 0.
        for (int y = 8; y <= 27; y++)
            for (int x = 16; x <= 79; x++)
                cycle(x, y, 0, 0, 0);

        // Gap between slots 0 and 1, into slot 1.
        for (int y = 8; y <= 9; y++)
            for (int x = 76; x <= 150; x++)
                cycle(x, y, 0, 0, 0);

        // Single loss then a full blink sequence on slot 2.
        cycle(200, 8, 0, 1, 0);
        slot2_frames(52);

        // Down to zero, ignored extra loss, recover, simultaneous request.
        cycle(20, 10, 0, 1, 0);
        cycle(90, 12, 0, 1, 0);
        cycle(30, 15, 0, 0, 0);
        cycle(30, 15, 0, 1, 0);
        cycle(30, 15, 0, 0, 0);
        cycle(40, 9, 0, 0, 1);
        cycle(100, 9, 0, 0, 1);
        cycle(100, 9, 0, 1, 1);
        cycle(100, 9, 0, 0, 0);
        cycle(160, 9, 0, 0, 0);

        // Reset mid-blink, mid-line.
        do_reset(2);
        cycle(200, 8, 0, 1, 0);
        slot2_frames(5);
        cycle(160, 10, 0, 0, 0);
        do_reset(3);
        for (int x = 150; x < 200; x++)
            cycle(x, 12, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cycle(int'($urandom_range(0, 260)), int'($urandom_range(0, 35)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 39) == 0));

        repeat (3) cycle(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("scoreboard_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/heart_display_ctrl.md
HEART_DISPLAY_CTRL -- requirements
Module: heart_display_ctrl

Interface
REQ-001 Parameter HEART_X0, default 16: screen x of heart slot 0's left column.
REQ-002 Parameter HEART_Y0, default 8: screen y of the top row of every slot.
REQ-003 Parameter HEART_PITCH, default 68: x distance between adjacent slots; must be ≥64.
REQ-004 Parameter MAX_LIVES, default 3, range 1..4: number of slots and the reset life count.
REQ-005 Parameter BLINK_PERIOD, default 8: frames per blink phase.
REQ-006 Parameter BLINK_TOGGLES, default 6: phase toggles per blink sequence.
REQ-007 clk  in  1: single clock domain; reset is asynchronous and active-low.
REQ-008 rst_n  in  1: asynchronous active-low reset.
REQ-009 hcount  in  10: current scan x.
REQ-010 vcount  in  10: current scan y.
REQ-011 frame_start  in  1: one-cycle pulse at the start of each frame.
REQ-012 life_lost  in  1: one-cycle decrement request.
REQ-013 life_gain  in  1: one-cycle increment request.
REQ-014 rom_x  out  6: sprite column address to the shared heart ROM.
REQ-015 rom_y  out  6: sprite row address to the shared heart ROM.
REQ-016 rom_rgb  in  16: ROM pixel, valid one cycle after its address.
REQ-017 pixel_rgb  out  16: heart overlay colour; 16'h0000 means transparent.
REQ-018 pixel_hit  out  1: pixel_rgb is an opaque heart pixel.
REQ-019 lives  out  3: current life count.
REQ-020 game_over  out  1: high while lives==0.

Function
REQ-021 Slot k (0..MAX_LIVES-1) region: x in [HEART_X0+k*HEART_PITCH, +63]; y in [HEART_Y0, HEART_Y0+19].
- rom_x, rom_y: combinational offsets into the slot containing (hcount,vcount); 0 outside every slot.
REQ-022 Stage 1 registers the hit flag: region hit AND slot visible.
REQ-023 Stage 2 registers the outputs:
- pixel_rgb = rom_rgb if the stage-1 hit flag is set and rom_rgb!=0, else 0.
- pixel_hit = (pixel_rgb!=0).
- Total latency: 2 cycles from hcount/vcount to pixel_rgb.
REQ-024 Slot k is visible if k<lives, or if k==blink_idx during BLINK in an "on" phase.
REQ-025 lives counter:
- life_lost with lives>0 decrements.
- life_gain with lives<MAX_LIVES increments.
- Simultaneous life_lost and life_gain: no change.
- life_lost at 0 and life_gain at MAX_LIVES are ignored.
REQ-026 Blink FSM states IDLE and BLINK:
- An accepted decrement enters BLINK with blink_idx = new lives value, phase "on", frame counter 0, toggle counter 0.
REQ-027 In BLINK, each frame_start advances the frame counter.
- At BLINK_PERIOD-1 the phase inverts and the toggle counter increments.
- After BLINK_TOGGLES toggles, return to IDLE.
REQ-028 BLINK boundary conditions:
- An accepted decrement in BLINK restarts the sequence on the new index.
- An accepted increment in BLINK returns to IDLE.
- Blink state changes take effect from the next cycle; there is no mid-frame latching.
REQ-029 game_over = (lives==0), registered, updating the cycle after the counter changes.

Reset
REQ-030 While rst_n==0 and after release:
- lives=MAX_LIVES, game_over=0.
- FSM=IDLE, all counters 0, pipeline flags 0.
- pixel_rgb=16'h0000, pixel_hit=0.
REQ-031 Reset asserted mid-blink or mid-line aborts immediately; there is no residual overlay output.

Configuration
REQ-032 Macro HEART_BLINK_EN:
- Defined: the blink FSM, counters and REQ-026..028 are present.
- Undefined: no blink logic; slot k is visible if k<lives, so a lost heart vanishes on the next cycle; all other behaviour is unchanged.

Structure
REQ-033 Package heart_pkg holds:
- sprite width 64 and height 20 constants;
- the transparent colour 16'h0000;
- the blink state enum {IDLE, BLINK}.
REQ-034 The blink FSM and its counters form sub-module heart_blink_fsm.
- It is instantiated only under HEART_BLINK_EN.
- The heart ROM itself stays external.

Verification
REQ-035 Bench ROM model returns 16'hf800 where the 64x20 bitmap is set, with 1-cycle latency. Directed scenarios:
- Reset, then scan (16,8)..(79,27): rom_x/rom_y sweep 0..63/0..19; pixel_rgb matches the bitmap exactly 2 cycles later.
- Scan (84,8) with default parameters: rom_x=0; slot 1 pixels appear; (80..83,y) stay transparent.
- One life_lost at lives=3 → lives=2; slot 2 alternates visible/hidden every 8 frames for 6 toggles, then stays hidden (HEART_BLINK_EN defined).
- Same stimulus without HEART_BLINK_EN → slot 2 hidden from the first frame.
- Three life_lost pulses → lives=0, game_over=1; a fourth is ignored; simultaneous life_lost+life_gain at lives=2 → no change.
- rst_n low during BLINK at frame 5 → all outputs at reset values; lives=3 after release.
